// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the uart_tx scheduler: scheduler state encoding
// and default parameter values for FIFO depth and launch-acknowledge timeout.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } sched_state_t;

    localparam int SCHED_DEPTH_DEF        = 4;
    localparam int SCHED_BUSY_TIMEOUT_DEF = 16;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Bundle of producer handshakes and transmitter-side signals of uart_tx_sched.
//   req0_*/req1_*  : valid/ready byte push from the two producers
//   tx_ctrl/tx_byte/transmit_ready : link to the shared uart_tx
//   grant_id/busy/timeout_err      : scheduler status
// slave  = scheduler side, master = producers + transmitter side.
interface uart_tx_sched_if;
    logic       req0_valid;
    logic [7:0] req0_byte;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_byte;
    logic       req1_ready;
    logic       tx_ctrl;
    logic [7:0] tx_byte;
    logic       transmit_ready;
    logic       grant_id;
    logic       busy;
    logic       timeout_err;

    modport slave (
        input  req0_valid, req0_byte, req1_valid, req1_byte, transmit_ready,
        output req0_ready, req1_ready, tx_ctrl, tx_byte, grant_id, busy, timeout_err
    );

    modport master (
        output req0_valid, req0_byte, req1_valid, req1_byte, transmit_ready,
        input  req0_ready, req1_ready, tx_ctrl, tx_byte, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/tx_req_fifo.sv
// Small per-requester byte FIFO, first-word-fall-through.
//   clk, nRst : clock, async active-low reset (empties the FIFO)
//   push/din  : write, ignored when full
//   pop       : drop head, ignored when empty
//   dout      : current head byte
//   full/empty: occupancy flags
module tx_req_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push, w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between two byte producers.
//   clk, nRst : clock, async active-low reset
//   bus       : uart_tx_sched_if.slave (producer pushes, tx link, status)
// A byte is popped on grant, launched with a one-cycle tx_ctrl pulse, and
// tx_byte is held until the transmitter reports idle again.
module uart_tx_sched
    import uart_ctrl_pkg::*;
#(
    parameter int DEPTH        = SCHED_DEPTH_DEF,
    parameter int BUSY_TIMEOUT = SCHED_BUSY_TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           nRst,
    uart_tx_sched_if.slave bus
);
    localparam int            TW       = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    sched_state_t    r_state;
    logic            r_tx_ctrl, r_grant_id, r_busy, r_timeout_err, r_last_grant;
    logic [7:0]      r_tx_byte;
    logic [TW-1:0]   r_timer;

    logic [1:0]      w_valid, w_full, w_empty, w_push, w_pop;
    logic [1:0][7:0] w_din, w_head;
    logic            w_gnt, w_grant_go;
    logic [TW-1:0]   w_timer_nxt;

    assign w_valid = {bus.req1_valid, bus.req0_valid};
    assign w_din   = {bus.req1_byte, bus.req0_byte};

    // Lone non-empty FIFO wins; on a tie the one not served last wins.
    assign w_gnt      = (~w_empty[0] & ~w_empty[1]) ? ~r_last_grant : w_empty[0];
    assign w_grant_go = (r_state == S_IDLE) & bus.transmit_ready & (w_empty != 2'b11);

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        assign w_push[g] = w_valid[g] & ~w_full[g];
        assign w_pop[g]  = w_grant_go & (w_gnt == 1'(g));
        tx_req_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .nRst  (nRst),
            .push  (w_push[g]),
            .din   (w_din[g]),
            .pop   (w_pop[g]),
            .dout  (w_head[g]),
            .full  (w_full[g]),
            .empty (w_empty[g])
        );
    end

    assign w_timer_nxt = r_timer + TW'(1);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state       <= S_IDLE;
            r_tx_ctrl     <= 1'b0;
            r_tx_byte     <= 8'h00;
            r_grant_id    <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_last_grant  <= 1'b1;
            r_timer       <= '0;
        end else begin
            r_tx_ctrl     <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_go) begin
                        r_tx_byte  <= w_head[w_gnt];
                        r_grant_id <= w_gnt;
                        r_tx_ctrl  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!bus.transmit_ready) begin
                        r_state <= S_WAIT_DONE;
                    end else if (w_timer_nxt == TMO_LAST) begin
                        // Launch never acknowledged: drop the byte, keep fairness history.
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_timer <= w_timer_nxt;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.transmit_ready) begin
                        r_last_grant <= r_grant_id;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_tx_ctrl     <= 1'b0;
                    r_tx_byte     <= 8'h00;
                    r_grant_id    <= 1'b0;
                    r_busy        <= 1'b0;
                    r_timeout_err <= 1'b0;
                    r_last_grant  <= 1'b1;
                    r_timer       <= '0;
                end
            endcase
        end
    end

    assign bus.req0_ready  = ~w_full[0];
    assign bus.req1_ready  = ~w_full[1];
    assign bus.tx_ctrl     = r_tx_ctrl;
    assign bus.tx_byte     = r_tx_byte;
    assign bus.grant_id    = r_grant_id;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: behavioural uart_tx model,
// scoreboard of expected (byte, grant) launches, directed timing checks.
module tb_uart_tx_sched;
    localparam int FRAME = 5;

    typedef struct {
        logic [7:0] b;
        logic       g;
    } exp_t;

    logic clk  = 1'b0;
    logic nRst = 1'b0;
    logic tx_dead = 1'b0;
    logic tx_hold = 1'b0;
    logic tr_model = 1'b1;
    int   tx_cnt = 0;

    int   n_chk = 0;
    int   n_err = 0;
    int   n_launch = 0;
    exp_t sb_q[$];

    uart_tx_sched_if bus ();

    uart_tx_sched #(.DEPTH(4), .BUSY_TIMEOUT(16)) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.transmit_ready = tx_hold ? 1'b0 : tr_model;

    // uart_tx model: ready drops one cycle after a sampled pulse, low FRAME cycles.
    initial begin
        forever begin
            @(posedge clk);
            if (!nRst) begin
                tr_model <= 1'b1;
                tx_cnt   <= 0;
            end else if (tx_cnt != 0) begin
                tx_cnt <= tx_cnt - 1;
                if (tx_cnt == 1) tr_model <= 1'b1;
            end else if (bus.tx_ctrl && tr_model && !tx_dead) begin
                tr_model <= 1'b0;
                tx_cnt   <= FRAME;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic sb_add(input logic [7:0] b, input logic g);
        exp_t e;
        e.b = b;
        e.g = g;
        sb_q.push_back(e);
    endtask

    // Launch monitor: pops scoreboard on every tx_ctrl, checks byte hold at frame end.
    initial begin
        exp_t e;
        logic [7:0] l_byte;
        bit in_frame, saw_low;
        in_frame = 0;
        saw_low  = 0;
        l_byte   = 8'h00;
        forever begin
            @(negedge clk);
            if (!nRst) begin
                in_frame = 0;
            end else if (bus.tx_ctrl) begin
                n_launch++;
                if (sb_q.size() == 0) begin
                    chk("extra_launch", {24'h0, bus.tx_byte}, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk("tx_byte", bus.tx_byte, e.b);
                    chk("grant_id", bus.grant_id, e.g);
                    l_byte = e.b;
                end
                in_frame = 1;
                saw_low  = 0;
            end else if (in_frame) begin
                if (bus.timeout_err) in_frame = 0;
                else if (!bus.transmit_ready) saw_low = 1;
                else if (saw_low) begin
                    chk("tx_byte_hold", bus.tx_byte, l_byte);
                    in_frame = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nRst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 nRst = 1'b1;
    endtask

    task automatic push_one(input bit id, input logic [7:0] b, input bit exp_ok);
        if (id) begin
            bus.req1_valid = 1'b1;
            bus.req1_byte  = b;
            chk("req1_ready", bus.req1_ready, exp_ok);
        end else begin
            bus.req0_valid = 1'b1;
            bus.req0_byte  = b;
            chk("req0_ready", bus.req0_ready, exp_ok);
        end
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic push2(input logic [7:0] b0, input logic [7:0] b1);
        bus.req0_valid = 1'b1;
        bus.req0_byte  = b0;
        bus.req1_valid = 1'b1;
        bus.req1_byte  = b1;
        chk("tie_ready0", bus.req0_ready, 1);
        chk("tie_ready1", bus.req1_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic wait_tr(input logic lvl);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.transmit_ready !== lvl && k < 100);
        chk("wait_tr", bus.transmit_ready, lvl);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || bus.busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("drain_sb", sb_q.size(), 0);
        chk("drain_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, nxt, k;
        bit early;
        bus.req0_valid = 1'b0;
        bus.req0_byte  = 8'h00;
        bus.req1_valid = 1'b0;
        bus.req1_byte  = 8'h00;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_ctrl", bus.tx_ctrl, 0);
        chk("rst_tx_byte", bus.tx_byte, 8'h00);
        chk("rst_grant", bus.grant_id, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tmo", bus.timeout_err, 0);
        chk("rst_ready0", bus.req0_ready, 1);
        chk("rst_ready1", bus.req1_ready, 1);
        @(posedge clk);
        #1 nRst = 1'b1;
        tick();

        // Single byte: pulse two cycles after push, busy clears after frame
        sb_add(8'hA5, 1'b0);
        push_one(1'b0, 8'hA5, 1'b1);
        @(negedge clk);
        chk("single_n1", bus.tx_ctrl, 0);
        @(negedge clk);
        chk("single_n2", bus.tx_ctrl, 1);
        chk("single_busy", bus.busy, 1);
        @(negedge clk);
        chk("single_once", bus.tx_ctrl, 0);
        wait_tr(1'b1);
        @(negedge clk);
        chk("single_idle", bus.busy, 0);
        drain(200);

        // Tie: strict alternation, requester 0 first after reset; frame gap
        do_reset();
        sb_add(8'h11, 1'b0);
        sb_add(8'h21, 1'b1);
        sb_add(8'h12, 1'b0);
        sb_add(8'h22, 1'b1);
        push2(8'h11, 8'h21);
        push2(8'h12, 8'h22);
        wait_tr(1'b0);
        wait_tr(1'b1);
        @(negedge clk);
        chk("gap_m1", bus.tx_ctrl, 0);
        @(negedge clk);
        chk("gap_m2", bus.tx_ctrl, 1);
        drain(300);

        // Full FIFO with transmitter held busy
        do_reset();
        tx_hold = 1'b1;
        base = n_launch;
        for (int i = 0; i < 5; i++) begin
            logic [7:0] v;
            v = 8'h40 + 8'(i);
            if (i < 4) sb_add(v, 1'b1);
            push_one(1'b1, v, (i < 4));
        end
        chk("full_ready0", bus.req0_ready, 1);
        repeat (5) @(negedge clk);
        chk("full_hold_nolaunch", n_launch - base, 0);
        tick();
        tx_hold = 1'b0;
        drain(300);
        chk("full_count", n_launch - base, 4);

        // Timeout: dead transmitter, pulse 16 cycles after tx_ctrl, next byte follows
        do_reset();
        tx_dead = 1'b1;
        sb_add(8'h3C, 1'b0);
        sb_add(8'h3D, 1'b0);
        push_one(1'b0, 8'h3C, 1'b1);
        push_one(1'b0, 8'h3D, 1'b1);
        @(negedge clk);
        chk("tmo_launch", bus.tx_ctrl, 1);
        early = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i < 16 && bus.timeout_err) early = 1;
        end
        chk("tmo_early", early, 0);
        chk("tmo_at16", bus.timeout_err, 1);
        @(negedge clk);
        chk("tmo_pulse1", bus.timeout_err, 0);
        chk("tmo_next", bus.tx_ctrl, 1);
        drain(100);
        tx_dead = 1'b0;

        // Reset during WAIT_DONE with two bytes queued
        do_reset();
        sb_add(8'h01, 1'b0);
        push_one(1'b0, 8'h01, 1'b1);
        push_one(1'b0, 8'h02, 1'b1);
        push_one(1'b0, 8'h03, 1'b1);
        wait_tr(1'b0);
        @(negedge clk);
        chk("mid_busy_pre", bus.busy, 1);
        nRst = 1'b0;
        #1;
        chk("mid_tx_ctrl", bus.tx_ctrl, 0);
        chk("mid_tx_byte", bus.tx_byte, 8'h00);
        chk("mid_busy", bus.busy, 0);
        chk("mid_grant", bus.grant_id, 0);
        chk("mid_ready0", bus.req0_ready, 1);
        base = n_launch;
        repeat (2) @(posedge clk);
        #1 nRst = 1'b1;
        repeat (30) @(negedge clk);
        chk("mid_noresend", n_launch - base, 0);
        chk("mid_sb", sb_q.size(), 0);

        // Push and pop together at count 3 across pointer wrap
        do_reset();
        tx_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb_add(8'(i), 1'b0);
            push_one(1'b0, 8'(i), 1'b1);
        end
        tx_hold = 1'b0;
        nxt = 3;
        k = 0;
        while (nxt < 20 && k < 2000) begin
            @(negedge clk);
            k++;
            if (!bus.busy && bus.transmit_ready) begin
                chk("pp_ready", bus.req0_ready, 1);
                sb_add(nxt[7:0], 1'b0);
                bus.req0_valid = 1'b1;
                bus.req0_byte  = nxt[7:0];
                nxt++;
            end else begin
                bus.req0_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        chk("pp_fed", nxt, 20);
        drain(500);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
